// File: rtl/button_pkg.sv
// Shared definitions for the button stimulus blocks: FSM encoding and the
// 16-bit Galois LFSR used for reproducible pseudorandom timing.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so that seed is remapped.
  function automatic logic [15:0] seed_guard(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advancing every clock; reusable by any
// block that needs reproducible pseudorandom stimulus.
module lfsr16 import button_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= seed_guard(seed);
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/button_bounce_gen.sv
// Push-button bounce emulator: turns a clean requested level into a burst of
// pseudorandom-width glitch pairs followed by a stable settle interval.
module button_bounce_gen import button_pkg::*; #(
  parameter int          MAX_BOUNCES   = 8,
  parameter int          MIN_GLITCH    = 4,
  parameter int          GLITCH_W      = 8,
  parameter int          SETTLE_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       target,
  input  logic       enable,
  output logic       out,
  output logic       busy,
  output logic       settle_done,
  output logic [7:0] bounce_count
);

  localparam int HOLD_W_SETTLE = $clog2(SETTLE_CYCLES + 1);
  localparam int HOLD_W_GLITCH = GLITCH_W + $clog2(MIN_GLITCH) + 1;
  localparam int HOLD_W = (HOLD_W_SETTLE > HOLD_W_GLITCH) ? HOLD_W_SETTLE : HOLD_W_GLITCH;
  localparam int PAIR_W = $clog2(MAX_BOUNCES) + 1;

  localparam logic [15:0]       PAIR_MASK   = 16'(MAX_BOUNCES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] SETTLE_LOAD = HOLD_W'(SETTLE_CYCLES);
  localparam logic [PAIR_W-1:0] PAIR_ONE    = PAIR_W'(1);

  state_t              state, state_n;
  logic                level, level_n;
  logic                out_n, done_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic [PAIR_W-1:0]   pairs, pairs_n;
  logic [7:0]          count_n, count_sat;
  logic [15:0]         lfsr;
  logic [HOLD_W-1:0]   glitch_load;
  logic [PAIR_W-1:0]   pair_load;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign glitch_load = HOLD_W'(MIN_GLITCH) + HOLD_W'(lfsr[GLITCH_W-1:0]);
  assign pair_load   = PAIR_W'(lfsr & PAIR_MASK) + PAIR_ONE;
  assign count_sat   = (bounce_count == 8'hFF) ? 8'hFF : bounce_count + 8'd1;
  assign busy        = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave a variable unassigned (no latch).
    state_n = state;
    level_n = level;
    out_n   = out;
    hold_n  = hold;
    pairs_n = pairs;
    count_n = bounce_count;
    done_n  = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      out_n   = target;
      level_n = target;
      hold_n  = '0;
      pairs_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (target != level) begin
            level_n = target;
            out_n   = target;
            count_n = 8'd1;
            pairs_n = pair_load;
            hold_n  = glitch_load;
            state_n = BOUNCE;
          end
        end
        BOUNCE: begin
          if (hold <= HOLD_ONE) begin
            out_n   = ~out;
            count_n = count_sat;
            hold_n  = glitch_load;
            // out != level means this toggle is the return edge of a pair.
            if (out != level) begin
              if (pairs <= PAIR_ONE) begin
                pairs_n = '0;
                hold_n  = SETTLE_LOAD;
                state_n = SETTLE;
              end else begin
                pairs_n = pairs - PAIR_ONE;
              end
            end
          end else begin
            hold_n = hold - HOLD_ONE;
          end
        end
        SETTLE: begin
          if (hold <= HOLD_ONE) begin
            done_n  = 1'b1;
            hold_n  = '0;
            state_n = IDLE;
          end else begin
            hold_n = hold - HOLD_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      level        <= 1'b0;
      out          <= 1'b0;
      hold         <= '0;
      pairs        <= '0;
      bounce_count <= 8'd0;
      settle_done  <= 1'b0;
    end else begin
      state        <= state_n;
      level        <= level_n;
      out          <= out_n;
      hold         <= hold_n;
      pairs        <= pairs_n;
      bounce_count <= count_n;
      settle_done  <= done_n;
    end
  end

endmodule

// File: doc/button_bounce_gen.md
Name: button_bounce_gen

Overview:
Synthesisable bounce emulator: the transmit-side counterpart of the button debouncer. It converts a clean requested level into the noisy waveform a mechanical push-button produces. Each level change emits a burst of pseudorandom-width glitches, then a stable settle interval. It drives the debouncer's button input in benches and in on-board self-test builds. It is fully deterministic for a given seed.

Parameters:
MAX_BOUNCES, 8, upper bound on glitch pairs per transition; power of 2, range 1..128
MIN_GLITCH, 4, minimum hold time of any bounce segment, in clk cycles (>=1)
GLITCH_W, 8, number of random bits added to the segment width (1..16)
SETTLE_CYCLES, 1000, stable cycles after the final edge before settle_done
LFSR_SEED, 16'hACE1, reset value of the LFSR; 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
target  input  1  clean requested button level
enable  input  1  1 = bounce emulation; 0 = registered pass-through
out  output  1  emulated noisy button signal, registered
busy  output  1  high in BOUNCE or SETTLE
settle_done  output  1  one-cycle pulse when SETTLE completes
bounce_count  output  8  edges emitted on out in the current or last transition; saturates at 255

Behaviour:
- Reset (async, active-high): out=0, level=0, state=IDLE, busy=0, settle_done=0, bounce_count=0, lfsr=LFSR_SEED (0 is mapped to 1), hold/pair counters=0.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every clk cycle in all states while not in reset.
- States are IDLE, BOUNCE and SETTLE; busy = (state != IDLE).
- IDLE, with enable=1 and target != level, sampled at edge t:
  - at t: level<=target; out<=target (first edge); bounce_count<=1
  - pairs_left<=1+(lfsr & (MAX_BOUNCES-1)); hold<=MIN_GLITCH+lfsr[GLITCH_W-1:0]; state<=BOUNCE
  - Latency is one cycle: out changes on the same edge that samples target.
- BOUNCE:
  - hold decrements each cycle. When hold reaches 1, out toggles and bounce_count increments (saturating).
  - A new hold is loaded from the current LFSR using the same formula.
  - Each pair is one toggle to the old level followed by one toggle back to level.
  - After the last pair's return edge (out==level), load hold=SETTLE_CYCLES and go to SETTLE.
  - Total edges per transition = 1 + 2*pairs; odd, range 3..2*MAX_BOUNCES+1.
  - Each segment is MIN_GLITCH..MIN_GLITCH+2^GLITCH_W-1 cycles wide.
- SETTLE:
  - out is held at level for exactly SETTLE_CYCLES cycles.
  - Then settle_done pulses high for 1 cycle and state goes to IDLE.
- target changes during BOUNCE or SETTLE are ignored. target is re-evaluated in IDLE on the cycle after settle_done. If it then differs from level, a new transition starts immediately.
- enable=0 (any state): state<=IDLE, out<=target, level<=target, busy=0, no settle_done. bounce_count holds.
- enable falling mid-BOUNCE: abort; out equals target one cycle later.
- enable rising in IDLE: if target==level there is no activity.
- reset mid-operation: everything returns to reset values immediately; any partial glitch is discarded.
- Widths: hold counter is max(clog2(SETTLE_CYCLES+1), GLITCH_W+clog2(MIN_GLITCH)+1) bits; pair counter is clog2(MAX_BOUNCES)+1 bits.
- No combinational path from any input to out.

Decomposition:
- Shared package button_pkg:
  - state encoding IDLE=2'd0, BOUNCE=2'd1, SETTLE=2'd2
  - LFSR_TAPS=16'hB400
  - LFSR_DEFAULT_SEED=16'hACE1
- Sub-module lfsr16: ports clk, reset, seed, state[15:0]. Free-running Galois LFSR with zero-seed guard, shared with any future random-stimulus blocks.
- The FSM, hold counter and pair counter stay in button_bounce_gen.

Test Plan:
1. Reset held 5 cycles then released, enable=0, target=0 -> out=0, busy=0, bounce_count=0, lfsr=16'hACE1 on the first cycle after release.
2. enable=0, target 0->1->0 at 10-cycle spacing -> out follows target exactly 1 cycle later; busy and settle_done stay 0.
3. MAX_BOUNCES=1, MIN_GLITCH=4, GLITCH_W=2, SETTLE_CYCLES=20, enable=1, target 0->1 -> exactly 3 edges on out (1,0,1). Each segment is 4..7 cycles. bounce_count=3. settle_done fires 20 cycles after the final edge, then busy=0. The sequence is identical across two runs with the same seed.
4. Default parameters, target 0->1, then target pulsed back to 0 mid-BOUNCE -> no reaction until settle_done. The next cycle starts a new transition to 0. Edge count per transition is odd and <=17.
5. Assert reset while state=BOUNCE and out=0 against level=1 -> out=0, busy=0 asynchronously. After release, LFSR restarts from the seed.
6. Chain out into the debouncer with SETTLE_CYCLES larger than the debounce window, and toggle target 4 times -> the debounced output shows exactly 4 clean edges, each one after its settle_done.
